move_drop_controller: RTL and testbench

//  Consumer of player move commands (valid_move pulse + selected_col) from the player input blocks.

---
 rtl/move_drop_if.sv | 33 +++
 rtl/move_drop_controller.sv | 189 ++++++++++++++++++
 tb/tb_move_drop_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/move_drop_if.sv
// Handshake and board-status bundle between the player input blocks and move_drop_controller.
interface move_drop_if #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
);
    logic                   valid_move;
    logic [2:0]             selected_col;
    logic                   player_id;
    logic                   clear_board;
    logic                   busy;
    logic                   move_done;
    logic                   move_invalid;
    logic [2:0]             last_row;
    logic [2:0]             last_col;
    logic [ROWS*COLS-1:0]   board_p1;
    logic [ROWS*COLS-1:0]   board_p2;
    logic                   board_full;
    logic                   anim_valid;
    logic [2:0]             anim_row;
    logic [2:0]             anim_col;

    modport master (
        output valid_move, selected_col, player_id, clear_board,
        input  busy, move_done, move_invalid, last_row, last_col,
        input  board_p1, board_p2, board_full, anim_valid, anim_row, anim_col
    );

    modport slave (
        input  valid_move, selected_col, player_id, clear_board,
        output busy, move_done, move_invalid, last_row, last_col,
        output board_p1, board_p2, board_full, anim_valid, anim_row, anim_col
    );
endinterface

// File: rtl/move_drop_controller.sv
// Connect-4 move validation and token drop into per-player occupancy bitmaps.
// Optional falling-token animation timing enabled by defining DROP_ANIM_EN.
module move_drop_controller #(
    parameter int unsigned ROWS       = 6,
    parameter int unsigned COLS       = 7,
    parameter int unsigned ANIM_TICKS = 5_000_000
) (
    input  logic         clk,
    input  logic         rst,
    move_drop_if.slave   bus
);
    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned HW   = $clog2(ROWS + 1);
    localparam int unsigned IDXW = $clog2(N);
    localparam logic [HW-1:0] ROWS_H = HW'(ROWS);

    if (ANIM_TICKS == 0) begin : g_bad_anim_ticks
        $error("ANIM_TICKS must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, CHECK, DROP, PLACE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      col_q, col_d;
    logic            player_q, player_d;
    logic [2:0]      target_q, target_d;
    logic [2:0]      cur_row_q, cur_row_d;
    logic [HW-1:0]   height_q [COLS];
    logic [HW-1:0]   height_d [COLS];
    logic [N-1:0]    board_p1_q, board_p1_d;
    logic [N-1:0]    board_p2_q, board_p2_d;
    logic [2:0]      last_row_q, last_row_d;
    logic [2:0]      last_col_q, last_col_d;
    logic            move_done_q, move_done_d;
    logic            move_invalid_q, move_invalid_d;

    logic [HW-1:0]   sel_height;
    logic [IDXW-1:0] place_idx;
    logic [N-1:0]    place_mask;
    logic            col_ok;
    logic            step_en;
    logic            full;

`ifdef DROP_ANIM_EN
    localparam int unsigned TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    logic [TW-1:0]   tick_q, tick_d;
`endif

    always_comb begin
        sel_height = '0;
        full       = 1'b1;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_q == 3'(c)) sel_height = height_q[c];
            if (height_q[c] != ROWS_H) full = 1'b0;
        end
        col_ok     = ({1'b0, col_q} < 4'(COLS));
        place_idx  = IDXW'(32'(target_q) * COLS + 32'(col_q));
        place_mask = {{(N-1){1'b0}}, 1'b1} << place_idx;
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        player_d       = player_q;
        target_d       = target_q;
        cur_row_d      = cur_row_q;
        height_d       = height_q;
        board_p1_d     = board_p1_q;
        board_p2_d     = board_p2_q;
        last_row_d     = last_row_q;
        last_col_d     = last_col_q;
        move_done_d    = 1'b0;
        move_invalid_d = 1'b0;
`ifdef DROP_ANIM_EN
        // Counter restarts on every row step and whenever DROP is left.
        step_en = (tick_q == TW'(ANIM_TICKS - 1));
        tick_d  = '0;
        if (state_q == DROP && !step_en) tick_d = tick_q + 1'b1;
`else
        step_en = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (bus.valid_move) begin
                    col_d    = bus.selected_col;
                    player_d = bus.player_id;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!col_ok || sel_height == ROWS_H) begin
                    move_invalid_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    target_d  = 3'(sel_height);
                    cur_row_d = 3'(ROWS - 1);
                    state_d   = DROP;
                end
            end
            DROP: begin
                if (step_en) begin
                    if (cur_row_q == target_q) state_d = PLACE;
                    else                       cur_row_d = cur_row_q - 1'b1;
                end
            end
            PLACE: begin
                if (player_q) board_p2_d = board_p2_q | place_mask;
                else          board_p1_d = board_p1_q | place_mask;
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (col_q == 3'(c) && height_q[c] != ROWS_H)
                        height_d[c] = height_q[c] + 1'b1;
                end
                last_row_d  = target_q;
                last_col_d  = col_q;
                move_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything above, including a coincident strobe or a PLACE.
        if (bus.clear_board) begin
            state_d        = IDLE;
            height_d       = '{default: '0};
            board_p1_d     = '0;
            board_p2_d     = '0;
            move_done_d    = 1'b0;
            move_invalid_d = 1'b0;
`ifdef DROP_ANIM_EN
            tick_d         = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            col_q          <= '0;
            player_q       <= 1'b0;
            target_q       <= '0;
            cur_row_q      <= '0;
            height_q       <= '{default: '0};
            board_p1_q     <= '0;
            board_p2_q     <= '0;
            last_row_q     <= '0;
            last_col_q     <= '0;
            move_done_q    <= 1'b0;
            move_invalid_q <= 1'b0;
`ifdef DROP_ANIM_EN
            tick_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            player_q       <= player_d;
            target_q       <= target_d;
            cur_row_q      <= cur_row_d;
            height_q       <= height_d;
            board_p1_q     <= board_p1_d;
            board_p2_q     <= board_p2_d;
            last_row_q     <= last_row_d;
            last_col_q     <= last_col_d;
            move_done_q    <= move_done_d;
            move_invalid_q <= move_invalid_d;
`ifdef DROP_ANIM_EN
            tick_q         <= tick_d;
`endif
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.move_done    = move_done_q;
    assign bus.move_invalid = move_invalid_q;
    assign bus.last_row     = last_row_q;
    assign bus.last_col     = last_col_q;
    assign bus.board_p1     = board_p1_q;
    assign bus.board_p2     = board_p2_q;
    assign bus.board_full   = full;
`ifdef DROP_ANIM_EN
    assign bus.anim_valid   = (state_q == DROP);
    assign bus.anim_row     = cur_row_q;
    assign bus.anim_col     = col_q;
`else
    assign bus.anim_valid   = 1'b0;
    assign bus.anim_row     = '0;
    assign bus.anim_col     = '0;
`endif
endmodule

// File: tb/tb_move_drop_controller.sv
// Directed self-checking bench for move_drop_controller (default build, 6x7 board).
module tb_move_drop_controller;
    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    move_drop_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    move_drop_controller #(.ROWS(ROWS), .COLS(COLS), .ANIM_TICKS(5_000_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.clear_board = 1'b1;
        cyc();
        bus.clear_board = 1'b0;
    endtask

    task automatic do_move(input logic [2:0] col, input logic pid,
                           output int lat, output logic done, output logic inv);
        bus.valid_move   = 1'b1;
        bus.selected_col = col;
        bus.player_id    = pid;
        cyc();
        bus.valid_move = 1'b0;
        lat  = -1;
        done = 1'b0;
        inv  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus.move_done || bus.move_invalid) begin
                lat  = i;
                done = bus.move_done;
                inv  = bus.move_invalid;
                break;
            end
        end
    endtask

    task automatic move_expect(input string tag, input logic [2:0] col, input logic pid,
                               input int exp_lat, input logic exp_done);
        int   lat;
        logic done, inv;
        do_move(col, pid, lat, done, inv);
        check_eq({tag, "_lat"},  64'(lat),  64'(exp_lat));
        check_eq({tag, "_done"}, 64'(done), 64'(exp_done));
        check_eq({tag, "_inv"},  64'(inv),  64'(!exp_done));
        cyc();
        check_eq({tag, "_pulse"}, 64'({bus.move_done, bus.move_invalid}), 64'(0));
    endtask

    initial begin
        int          pulses, dones, invs;
        logic [63:0] e1, e2;

        bus.valid_move   = 1'b0;
        bus.selected_col = '0;
        bus.player_id    = 1'b0;
        bus.clear_board  = 1'b0;
        repeat (3) cyc();
        check_eq("rst_busy",  64'(bus.busy), 64'(0));
        check_eq("rst_p1",    64'(bus.board_p1), 64'(0));
        check_eq("rst_p2",    64'(bus.board_p2), 64'(0));
        check_eq("rst_full",  64'(bus.board_full), 64'(0));
        check_eq("rst_last",  64'({bus.last_row, bus.last_col}), 64'(0));
        rst = 1'b1;
        cyc();

        // Single move into an empty column
        move_expect("t2", 3'd3, 1'b0, 8, 1'b1);
        check_eq("t2_p1",   64'(bus.board_p1), 64'h8);
        check_eq("t2_p2",   64'(bus.board_p2), 64'h0);
        check_eq("t2_row",  64'(bus.last_row), 64'd0);
        check_eq("t2_col",  64'(bus.last_col), 64'd3);
        check_eq("t2_anim", 64'(bus.anim_valid), 64'd0);
        clear();
        check_eq("clr_p1",   64'(bus.board_p1), 64'h0);
        check_eq("clr_busy", 64'(bus.busy), 64'd0);

        // Fill column 0, then overflow it and try an out-of-range column
        for (int i = 0; i < 6; i++)
            move_expect("t3_fill", 3'd0, 1'(i % 2), 8 - i, 1'b1);
        check_eq("t3_p1", 64'(bus.board_p1), 64'h10004001);
        check_eq("t3_p2", 64'(bus.board_p2), 64'h800200080);
        move_expect("t3_full", 3'd0, 1'b1, 1, 1'b0);
        check_eq("t3_full_p1", 64'(bus.board_p1), 64'h10004001);
        check_eq("t3_full_p2", 64'(bus.board_p2), 64'h800200080);
        move_expect("t3_col7", 3'd7, 1'b0, 1, 1'b0);
        check_eq("t3_col7_p1", 64'(bus.board_p1), 64'h10004001);
        check_eq("t3_col7_p2", 64'(bus.board_p2), 64'h800200080);
        check_eq("t3_last", 64'({bus.last_row, bus.last_col}), 64'({3'd5, 3'd0}));

        // Strobes while busy are ignored
        clear();
        bus.valid_move   = 1'b1;
        bus.selected_col = 3'd4;
        bus.player_id    = 1'b1;
        cyc();
        dones = 0;
        invs  = 0;
        for (int i = 1; i <= 20; i++) begin
            bus.valid_move   = (i == 2 || i == 4);
            bus.selected_col = 3'd5;
            bus.player_id    = 1'b0;
            cyc();
            if (bus.move_done)    dones++;
            if (bus.move_invalid) invs++;
        end
        bus.valid_move = 1'b0;
        check_eq("t4_dones", 64'(dones), 64'd1);
        check_eq("t4_invs",  64'(invs),  64'd0);
        check_eq("t4_p2",    64'(bus.board_p2), 64'h10);
        check_eq("t4_p1",    64'(bus.board_p1), 64'h0);
        check_eq("t4_col",   64'(bus.last_col), 64'd4);

        // Clear during DROP aborts the move
        clear();
        move_expect("t5_pre", 3'd1, 1'b0, 8, 1'b1);
        bus.valid_move   = 1'b1;
        bus.selected_col = 3'd6;
        bus.player_id    = 1'b0;
        cyc();
        bus.valid_move = 1'b0;
        cyc();
        cyc();
        check_eq("t5_busy_drop", 64'(bus.busy), 64'd1);
        clear();
        check_eq("t5_busy", 64'(bus.busy), 64'd0);
        check_eq("t5_p1",   64'(bus.board_p1), 64'h0);
        check_eq("t5_p2",   64'(bus.board_p2), 64'h0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.move_done || bus.move_invalid) pulses++;
        end
        check_eq("t5_pulses", 64'(pulses), 64'd0);
        move_expect("t5_next", 3'd2, 1'b1, 8, 1'b1);
        check_eq("t5_next_p2",  64'(bus.board_p2), 64'h4);
        check_eq("t5_next_row", 64'(bus.last_row), 64'd0);

        // Fill the whole board alternating players
        clear();
        e1 = '0;
        e2 = '0;
        for (int m = 0; m < 42; m++) begin
            if (m == 41) check_eq("t6_notfull", 64'(bus.board_full), 64'd0);
            move_expect("t6_fill", 3'(m % 7), 1'(m % 2), 8 - m / 7, 1'b1);
            if (m % 2 == 0) e1[m] = 1'b1;
            else            e2[m] = 1'b1;
        end
        check_eq("t6_full",  64'(bus.board_full), 64'd1);
        check_eq("t6_p1",    64'(bus.board_p1), e1);
        check_eq("t6_p2",    64'(bus.board_p2), e2);
        check_eq("t6_pop1",  64'($countones(bus.board_p1)), 64'd21);
        check_eq("t6_pop2",  64'($countones(bus.board_p2)), 64'd21);
        check_eq("t6_and",   64'(bus.board_p1 & bus.board_p2), 64'd0);
        move_expect("t6_over", 3'd0, 1'b0, 1, 1'b0);

        // Asynchronous reset mid-DROP
        clear();
        move_expect("t1_pre", 3'd0, 1'b0, 8, 1'b1);
        bus.valid_move   = 1'b1;
        bus.selected_col = 3'd1;
        bus.player_id    = 1'b1;
        cyc();
        bus.valid_move = 1'b0;
        cyc();
        cyc();
        check_eq("t1_busy_drop", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t1_busy",  64'(bus.busy), 64'd0);
        check_eq("t1_p1",    64'(bus.board_p1), 64'h0);
        check_eq("t1_p2",    64'(bus.board_p2), 64'h0);
        check_eq("t1_pulse", 64'({bus.move_done, bus.move_invalid}), 64'd0);
        check_eq("t1_last",  64'({bus.last_row, bus.last_col}), 64'd0);
        check_eq("t1_full",  64'(bus.board_full), 64'd0);
        check_eq("t1_anim",  64'({bus.anim_valid, bus.anim_row, bus.anim_col}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.move_done || bus.move_invalid || bus.busy) pulses++;
        end
        check_eq("t1_after", 64'(pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
